// File: rtl/trap_event_collector.sv
// Collects per-thread good/bad trap hits, issues a sticky PASS/FAIL verdict, then pulses stop.
// Optional duplicate-good-trap check is compiled in with TRAP_COLLECT_DUP_CHK_EN.
module trap_event_collector #(
  parameter int unsigned NUM_THREADS    = 4,
  parameter int unsigned TID_W          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 32'd1000000,
  parameter int unsigned KILL_WAIT      = 2
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic [NUM_THREADS-1:0] thr_en,
  input  logic [NUM_THREADS-1:0] trap_vld,
  input  logic [NUM_THREADS-1:0] trap_bad,
  output logic [NUM_THREADS-1:0] good_mask,
  output logic                   pass,
  output logic                   fail,
  output logic [1:0]             fail_code,
  output logic [TID_W-1:0]       fail_tid,
  output logic                   stop,
  output logic [31:0]            cycle_cnt
);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  localparam logic [1:0] CodeBad     = 2'b01;
  localparam logic [1:0] CodeTimeout = 2'b10;
  localparam logic [1:0] CodeDup     = 2'b11;

  state_e                 state_q, state_d;
  logic [NUM_THREADS-1:0] mask_q, mask_d;
  logic                   pass_q, pass_d;
  logic                   fail_q, fail_d;
  logic [1:0]             code_q, code_d;
  logic [TID_W-1:0]       tid_q, tid_d;
  logic                   stop_q, stop_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [31:0]            drain_q, drain_d;

  logic [NUM_THREADS-1:0] good_vec, bad_vec, dup_vec, next_mask;
  logic [TID_W-1:0]       bad_tid, dup_tid;
  logic                   timeout_hit, all_good;

  always_comb begin
    good_vec  = trap_vld & ~trap_bad;
    bad_vec   = trap_vld & trap_bad;
    next_mask = mask_q | good_vec;

    // Descending scans so the lowest set index is the one left standing.
    bad_tid = '0;
    for (int i = int'(NUM_THREADS) - 1; i >= 0; i--) begin
      if (bad_vec[i]) bad_tid = TID_W'(i);
    end

`ifdef TRAP_COLLECT_DUP_CHK_EN
    dup_vec = good_vec & mask_q;
    dup_tid = '0;
    for (int i = int'(NUM_THREADS) - 1; i >= 0; i--) begin
      if (dup_vec[i]) dup_tid = TID_W'(i);
    end
`else
    dup_vec = '0;
    dup_tid = '0;
`endif

    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));
    all_good    = (thr_en != '0) && ((next_mask & thr_en) == thr_en);
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    code_d  = code_q;
    tid_d   = tid_q;
    stop_d  = 1'b0;
    drain_d = drain_q;
    cnt_d   = (cnt_q != 32'hFFFF_FFFF) ? cnt_q + 32'd1 : cnt_q;

    unique case (state_q)
      StRun: begin
        mask_d = next_mask;
        if (bad_vec != '0) begin
          fail_d = 1'b1;
          code_d = CodeBad;
          tid_d  = bad_tid;
        end else if (dup_vec != '0) begin
          fail_d = 1'b1;
          code_d = CodeDup;
          tid_d  = dup_tid;
        end else if (timeout_hit) begin
          fail_d = 1'b1;
          code_d = CodeTimeout;
          tid_d  = '0;
        end else if (all_good) begin
          pass_d = 1'b1;
        end
        if (fail_d || pass_d) begin
          state_d = StDrain;
          drain_d = 32'(KILL_WAIT);
        end
      end
      StDrain: begin
        if (drain_q <= 32'd1) begin
          state_d = StDone;
          stop_d  = 1'b1;
        end else begin
          drain_d = drain_q - 32'd1;
        end
      end
      StDone: begin
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= StRun;
      mask_q  <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      code_q  <= 2'b00;
      tid_q   <= '0;
      stop_q  <= 1'b0;
      cnt_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      code_q  <= code_d;
      tid_q   <= tid_d;
      stop_q  <= stop_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end

  assign good_mask = mask_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign fail_code = code_q;
  assign fail_tid  = tid_q;
  assign stop      = stop_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_trap_event_collector.sv
// Self-checking bench for trap_event_collector: directed scenarios plus randomized traffic
// compared against a verdict-level reference model.
module tb_trap_event_collector;

  localparam int unsigned Nt       = 4;
  localparam int unsigned TidW     = 2;
  localparam int unsigned Timeout  = 100;
  localparam int unsigned KillWait = 2;
`ifdef TRAP_COLLECT_DUP_CHK_EN
  localparam bit DupEn = 1'b1;
`else
  localparam bit DupEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_l;
  logic [Nt-1:0]   thr_en, trap_vld, trap_bad, good_mask;
  logic            pass, fail, stop;
  logic [1:0]      fail_code;
  logic [TidW-1:0] fail_tid;
  logic [31:0]     cycle_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [3:0] m_mask;
  logic       m_pass, m_fail;
  logic [1:0] m_code;
  logic [1:0] m_tid;
  int         m_vc;

  trap_event_collector #(
    .NUM_THREADS   (Nt),
    .TID_W         (TidW),
    .TIMEOUT_CYCLES(Timeout),
    .KILL_WAIT     (KillWait)
  ) dut (
    .clk      (clk),
    .rst_l    (rst_l),
    .thr_en   (thr_en),
    .trap_vld (trap_vld),
    .trap_bad (trap_bad),
    .good_mask(good_mask),
    .pass     (pass),
    .fail     (fail),
    .fail_code(fail_code),
    .fail_tid (fail_tid),
    .stop     (stop),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic do_reset();
    rst_l    = 1'b0;
    trap_vld = '0;
    trap_bad = '0;
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b1;
  endtask

  task automatic tick(input logic [3:0] vld, input logic [3:0] bad);
    trap_vld = vld;
    trap_bad = bad;
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_mask = '0; m_pass = 0; m_fail = 0; m_code = 0; m_tid = 0; m_vc = -1;
  endtask

  // Applies the verdict rules to one cycle of input seen while cycle_cnt == c.
  task automatic model_step(input logic [3:0] vld, input logic [3:0] bad, input int c);
    logic [3:0] g, b, nm;
    if (m_vc >= 0) return;
    g  = vld & ~bad;
    b  = vld & bad;
    nm = m_mask | g;
    if (b != 0) begin
      m_fail = 1; m_code = 2'b01; m_tid = lowest(b);
    end else if (DupEn && (g & m_mask) != 0) begin
      m_fail = 1; m_code = 2'b11; m_tid = lowest(g & m_mask);
    end else if (c == int'(Timeout) - 1) begin
      m_fail = 1; m_code = 2'b10; m_tid = 0;
    end else if (thr_en != 0 && (nm & thr_en) == thr_en) begin
      m_pass = 1;
    end
    if (m_pass || m_fail) m_vc = c;
    m_mask = nm;
  endtask

  task automatic test_reset();
    thr_en = 4'b1111;
    do_reset();
    checks++;
    if ({good_mask, pass, fail, fail_code, fail_tid, stop} !== 11'b0 || cycle_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset got=%b cnt=%0d exp=0 cnt=0",
               {good_mask, pass, fail, fail_code, fail_tid, stop}, cycle_cnt);
    end
  endtask

  task automatic test_pass_two_threads();
    logic [3:0] em;
    do_reset();
    thr_en = 4'b0101;
    for (int c = 0; c < 26; c++) begin
      tick((c == 10) ? 4'b0001 : (c == 20) ? 4'b0100 : 4'b0000, 4'b0000);
      em = (c + 1 >= 21) ? 4'b0101 : (c + 1 >= 11) ? 4'b0001 : 4'b0000;
      checks++;
      if ({good_mask, pass, fail, stop} !== {em, c + 1 >= 21, 1'b0, c + 1 == 23} ||
          cycle_cnt !== 32'(c + 1)) begin
        failures++;
        $display("FAIL pass_two cnt=%0d got=%b exp=%b", cycle_cnt,
                 {good_mask, pass, fail, stop}, {em, c + 1 >= 21, 1'b0, c + 1 == 23});
      end
    end
  endtask

  task automatic test_bad_same_cycle();
    int stops = 0;
    do_reset();
    thr_en = 4'b1111;
    for (int c = 0; c < 16; c++) begin
      if (c == 2)      tick(4'b0001, 4'b0000);
      else if (c == 5) tick(4'b1010, 4'b1010);
      else if (c == 8) tick(4'b0110, 4'b0000);
      else             tick(4'b0000, 4'b0000);
      if (stop) stops++;
      checks++;
      if (c + 1 >= 6 && {good_mask, pass, fail, fail_code, fail_tid, stop} !==
          {4'b0001, 1'b0, 1'b1, 2'b01, 2'd1, c + 1 == 8}) begin
        failures++;
        $display("FAIL bad_same cnt=%0d got=%b exp=%b", cycle_cnt,
                 {good_mask, pass, fail, fail_code, fail_tid, stop},
                 {4'b0001, 1'b0, 1'b1, 2'b01, 2'd1, c + 1 == 8});
      end else if (c + 1 < 6 && fail !== 1'b0) begin
        failures++;
        $display("FAIL bad_early cnt=%0d fail=%b exp=0", cycle_cnt, fail);
      end
    end
    checks++;
    if (stops != 1) begin
      failures++;
      $display("FAIL bad_stop_count got=%0d exp=1", stops);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    thr_en = 4'b1111;
    for (int c = 0; c < 106; c++) begin
      tick(4'b0000, 4'b0000);
      checks++;
      if ({pass, fail, fail_code, fail_tid, stop} !==
          {1'b0, c + 1 >= 100, (c + 1 >= 100) ? 2'b10 : 2'b00, 2'd0, c + 1 == 102}) begin
        failures++;
        $display("FAIL timeout cnt=%0d got=%b exp=%b", cycle_cnt,
                 {pass, fail, fail_code, fail_tid, stop},
                 {1'b0, c + 1 >= 100, (c + 1 >= 100) ? 2'b10 : 2'b00, 2'd0, c + 1 == 102});
      end
    end
  endtask

  task automatic test_good_and_bad_same();
    do_reset();
    thr_en = 4'b0001;
    tick(4'b0000, 4'b0000);
    tick(4'b0011, 4'b0010);
    tick(4'b0000, 4'b0000);
    checks++;
    if ({good_mask, pass, fail, fail_code, fail_tid} !== {4'b0001, 1'b0, 1'b1, 2'b01, 2'd1}) begin
      failures++;
      $display("FAIL good_bad got=%b exp=%b", {good_mask, pass, fail, fail_code, fail_tid},
               {4'b0001, 1'b0, 1'b1, 2'b01, 2'd1});
    end
  endtask

  task automatic test_duplicate();
    do_reset();
    thr_en = 4'b0011;
    for (int c = 0; c < 12; c++) begin
      if (c == 2 || c == 5) tick(4'b0001, 4'b0000);
      else if (c == 8)      tick(4'b0010, 4'b0000);
      else                  tick(4'b0000, 4'b0000);
      if (c + 1 == 7) begin
        checks++;
        if (DupEn && {pass, fail, fail_code, fail_tid} !== {1'b0, 1'b1, 2'b11, 2'd0}) begin
          failures++;
          $display("FAIL dup_on got=%b exp=%b", {pass, fail, fail_code, fail_tid},
                   {1'b0, 1'b1, 2'b11, 2'd0});
        end else if (!DupEn && {pass, fail, fail_code} !== 4'b0000) begin
          failures++;
          $display("FAIL dup_off got=%b exp=0000", {pass, fail, fail_code});
        end
      end
    end
    checks++;
    if (!DupEn && {good_mask, pass, fail} !== {4'b0011, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL dup_off_pass got=%b exp=%b", {good_mask, pass, fail}, {4'b0011, 1'b1, 1'b0});
    end else if (DupEn && {good_mask, fail_code} !== {4'b0001, 2'b11}) begin
      failures++;
      $display("FAIL dup_on_frozen got=%b exp=%b", {good_mask, fail_code}, {4'b0001, 2'b11});
    end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    thr_en = 4'b0001;
    for (int c = 0; c < 5; c++) tick((c == 3) ? 4'b0001 : 4'b0000, 4'b0000);
    checks++;
    if ({pass, stop} !== 2'b10) begin
      failures++;
      $display("FAIL drain_pre got=%b exp=10", {pass, stop});
    end
    rst_l = 1'b0;
    #1;
    checks++;
    if ({good_mask, pass, fail, fail_code, fail_tid, stop} !== 11'b0 || cycle_cnt !== 32'd0) begin
      failures++;
      $display("FAIL drain_reset got=%b cnt=%0d exp=0 cnt=0",
               {good_mask, pass, fail, fail_code, fail_tid, stop}, cycle_cnt);
    end
    @(negedge clk);
    rst_l = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick(4'b0000, 4'b0000);
      checks++;
      if (stop !== 1'b0 || pass !== 1'b0 || cycle_cnt !== 32'(c + 1)) begin
        failures++;
        $display("FAIL drain_after cnt=%0d stop=%b pass=%b exp cnt=%0d stop=0 pass=0",
                 cycle_cnt, stop, pass, c + 1);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] vld, bad;
    for (int it = 0; it < 20; it++) begin
      do_reset();
      model_reset();
      thr_en = 4'($urandom_range(0, 15));
      for (int c = 0; c < 110; c++) begin
        vld = 4'($urandom) & 4'($urandom) & 4'($urandom);
        bad = ($urandom_range(0, 11) == 0) ? (vld & 4'($urandom)) : 4'b0000;
        model_step(vld, bad, c);
        tick(vld, bad);
        checks++;
        if ({good_mask, pass, fail, fail_code, fail_tid, stop} !==
            {m_mask, m_pass, m_fail, m_code, m_tid,
             m_vc >= 0 && c + 1 == m_vc + 1 + int'(KillWait)} ||
            cycle_cnt !== 32'(c + 1)) begin
          failures++;
          $display("FAIL random it=%0d cnt=%0d got=%b exp=%b", it, cycle_cnt,
                   {good_mask, pass, fail, fail_code, fail_tid, stop},
                   {m_mask, m_pass, m_fail, m_code, m_tid,
                    m_vc >= 0 && c + 1 == m_vc + 1 + int'(KillWait)});
        end
      end
    end
  endtask

  initial begin
    rst_l    = 1'b0;
    thr_en   = '0;
    trap_vld = '0;
    trap_bad = '0;
    test_reset();
    test_pass_two_threads();
    test_bad_same_cycle();
    test_timeout();
    test_good_and_bad_same();
    test_duplicate();
    test_reset_in_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
